// File: rtl/hawk_tol_list_mngr.sv
// hawk_tol_list_mngr: head/tail/count bookkeeping for NUM_LISTS doubly linked
// lists sharing one pool of entry IDs (1..ENTRY_CNT, 0 is the NULL link).
// After reset every entry is chained into list 0 (FREE), one entry per cycle.
// Commands are push-tail, pop-head and detach. Each command is answered by a
// single response strobe on the cycle after it is accepted.
module hawk_tol_list_mngr #(
    parameter int NUM_LISTS = 8,
    parameter int ENTRY_CNT = 16,
    parameter int ID_W      = $clog2(ENTRY_CNT + 1),
    parameter int LW        = (NUM_LISTS > 1) ? $clog2(NUM_LISTS) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            init_done_o,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [1:0]      req_op_i,
    input  logic [LW-1:0]   req_list_i,
    input  logic [ID_W-1:0] req_eid_i,
    output logic            resp_valid_o,
    output logic [ID_W-1:0] resp_eid_o,
    output logic            resp_err_o,
    input  logic [LW-1:0]   qry_list_i,
    output logic [ID_W-1:0] qry_head_o,
    output logic [ID_W-1:0] qry_tail_o,
    output logic [ID_W-1:0] qry_count_o
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_RESP
    } state_t;

    localparam logic [1:0]      OP_PUSH   = 2'd0;
    localparam logic [1:0]      OP_POP    = 2'd1;
    localparam logic [1:0]      OP_DETACH = 2'd2;

    // An owner value equal to NUM_LISTS marks an entry that sits on no list.
    localparam logic [LW:0]     UNOWNED   = (LW + 1)'(NUM_LISTS);
    localparam logic [ID_W-1:0] NULL_ID   = '0;
    localparam logic [ID_W-1:0] ONE_ID    = ID_W'(1);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(ENTRY_CNT);

    state_t          r_state;
    state_t          w_stateNext;
    logic [ID_W-1:0] r_idx;

    logic [ID_W-1:0] r_next  [0:ENTRY_CNT];
    logic [ID_W-1:0] r_prev  [0:ENTRY_CNT];
    logic [LW:0]     r_owner [0:ENTRY_CNT];
    logic [ID_W-1:0] r_head  [0:NUM_LISTS-1];
    logic [ID_W-1:0] r_tail  [0:NUM_LISTS-1];
    logic [ID_W-1:0] r_count [0:NUM_LISTS-1];

    logic [ID_W-1:0] r_respEid;
    logic            r_respErr;

    logic            w_accept;
    logic            w_listOk;
    logic [LW-1:0]   w_listIdx;
    logic            w_eidOk;
    logic [ID_W-1:0] w_eidIdx;
    logic [ID_W-1:0] w_head;
    logic [ID_W-1:0] w_tail;
    logic [ID_W-1:0] w_count;
    logic [LW:0]     w_eidOwner;
    logic [ID_W-1:0] w_eidNext;
    logic [ID_W-1:0] w_eidPrev;
    logic [ID_W-1:0] w_popNext;
    logic            w_err;
    logic [ID_W-1:0] w_respEid;
    logic            w_qryOk;
    logic [LW-1:0]   w_qryIdx;

    // Decode the presented command against the current link registers.
    // Out-of-range list or entry indices are folded to 0 so that every array
    // read stays in range. Such commands are flagged as errors anyway.
    always_comb begin
        w_listOk   = ({1'b0, req_list_i} < UNOWNED);
        w_listIdx  = w_listOk ? req_list_i : '0;
        w_eidOk    = (req_eid_i != NULL_ID) && (req_eid_i <= LAST_ID);
        w_eidIdx   = w_eidOk ? req_eid_i : NULL_ID;
        w_head     = r_head[w_listIdx];
        w_tail     = r_tail[w_listIdx];
        w_count    = r_count[w_listIdx];
        w_eidOwner = r_owner[w_eidIdx];
        w_eidNext  = r_next[w_eidIdx];
        w_eidPrev  = r_prev[w_eidIdx];
        w_popNext  = r_next[w_head];
        w_err      = 1'b0;
        w_respEid  = NULL_ID;
        if (!w_listOk) begin
            w_err = 1'b1;
        end else begin
            case (req_op_i)
                OP_PUSH: begin
                    w_err     = !w_eidOk || (w_eidOwner != UNOWNED);
                    w_respEid = req_eid_i;
                end
                OP_POP: begin
                    w_err     = (w_count == NULL_ID);
                    w_respEid = w_head;
                end
                OP_DETACH: begin
                    w_err     = !w_eidOk || (w_eidOwner != {1'b0, req_list_i});
                    w_respEid = req_eid_i;
                end
                default: w_err = 1'b1;
            endcase
        end
        if (w_err) begin
            w_respEid = NULL_ID;
        end
    end

    // State register. Reset always returns to the free-list build.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state and handshake outputs. While reset is high, every output is
    // forced low so that an interrupted response cannot leak out.
    always_comb begin
        w_stateNext  = r_state;
        w_accept     = 1'b0;
        init_done_o  = 1'b0;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_eid_o   = NULL_ID;
        resp_err_o   = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_idx == LAST_ID) begin
                    w_stateNext = ST_IDLE;
                end
            end
            ST_IDLE: begin
                init_done_o = 1'b1;
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    w_accept    = 1'b1;
                    w_stateNext = ST_RESP;
                end
            end
            ST_RESP: begin
                init_done_o  = 1'b1;
                resp_valid_o = 1'b1;
                resp_eid_o   = r_respEid;
                resp_err_o   = r_respErr;
                w_stateNext  = ST_IDLE;
            end
            default: w_stateNext = ST_INIT;
        endcase
        if (rst_i) begin
            w_accept     = 1'b0;
            init_done_o  = 1'b0;
            req_ready_o  = 1'b0;
            resp_valid_o = 1'b0;
            resp_eid_o   = NULL_ID;
            resp_err_o   = 1'b0;
        end
    end

    // Link storage: chain the free list during INIT, then commit accepted
    // commands in the accept cycle. Errored commands only latch their response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_idx     <= ONE_ID;
            r_respEid <= NULL_ID;
            r_respErr <= 1'b0;
            for (int k = 0; k <= ENTRY_CNT; k++) begin
                r_next[k]  <= NULL_ID;
                r_prev[k]  <= NULL_ID;
                r_owner[k] <= UNOWNED;
            end
            for (int l = 0; l < NUM_LISTS; l++) begin
                r_head[l]  <= NULL_ID;
                r_tail[l]  <= NULL_ID;
                r_count[l] <= NULL_ID;
            end
        end else begin
            if (r_state == ST_INIT) begin
                r_next[r_idx]  <= (r_idx == LAST_ID) ? NULL_ID : r_idx + ONE_ID;
                r_prev[r_idx]  <= r_idx - ONE_ID;
                r_owner[r_idx] <= '0;
                r_idx          <= r_idx + ONE_ID;
                if (r_idx == LAST_ID) begin
                    r_head[0]  <= ONE_ID;
                    r_tail[0]  <= LAST_ID;
                    r_count[0] <= LAST_ID;
                end
            end
            if (w_accept) begin
                r_respEid <= w_respEid;
                r_respErr <= w_err;
                if (!w_err) begin
                    case (req_op_i)
                        OP_PUSH: begin
                            r_next[w_eidIdx]   <= NULL_ID;
                            r_prev[w_eidIdx]   <= w_tail;
                            r_owner[w_eidIdx]  <= {1'b0, req_list_i};
                            r_count[w_listIdx] <= w_count + ONE_ID;
                            r_tail[w_listIdx]  <= w_eidIdx;
                            if (w_count == NULL_ID) begin
                                r_head[w_listIdx] <= w_eidIdx;
                            end else begin
                                r_next[w_tail] <= w_eidIdx;
                            end
                        end
                        OP_POP: begin
                            r_head[w_listIdx]  <= w_popNext;
                            r_owner[w_head]    <= UNOWNED;
                            r_count[w_listIdx] <= w_count - ONE_ID;
                            if (w_count == ONE_ID) begin
                                r_tail[w_listIdx] <= NULL_ID;
                            end else begin
                                r_prev[w_popNext] <= NULL_ID;
                            end
                        end
                        OP_DETACH: begin
                            if ((w_head == w_eidIdx) && (w_tail == w_eidIdx)) begin
                                r_head[w_listIdx] <= NULL_ID;
                                r_tail[w_listIdx] <= NULL_ID;
                            end else if (w_head == w_eidIdx) begin
                                r_head[w_listIdx] <= w_eidNext;
                                r_prev[w_eidNext] <= NULL_ID;
                            end else if (w_tail == w_eidIdx) begin
                                r_tail[w_listIdx] <= w_eidPrev;
                                r_next[w_eidPrev] <= NULL_ID;
                            end else begin
                                r_next[w_eidPrev] <= w_eidNext;
                                r_prev[w_eidNext] <= w_eidPrev;
                            end
                            r_owner[w_eidIdx]  <= UNOWNED;
                            r_count[w_listIdx] <= w_count - ONE_ID;
                            r_next[w_eidIdx]   <= NULL_ID;
                            r_prev[w_eidIdx]   <= NULL_ID;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Query port reads the list registers directly. Unknown lists read as empty.
    always_comb begin
        w_qryOk     = ({1'b0, qry_list_i} < UNOWNED);
        w_qryIdx    = w_qryOk ? qry_list_i : '0;
        qry_head_o  = w_qryOk ? r_head[w_qryIdx]  : NULL_ID;
        qry_tail_o  = w_qryOk ? r_tail[w_qryIdx]  : NULL_ID;
        qry_count_o = w_qryOk ? r_count[w_qryIdx] : NULL_ID;
    end

endmodule

// File: tb/tb_hawk_tol_list_mngr.sv
// Directed testbench for hawk_tol_list_mngr: free-list build, push/pop/detach,
// error rejection, drain to empty and reset restarts. A second instance with
// six lists exercises out-of-range list indices.
module tb_hawk_tol_list_mngr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       init_done_o;
    logic       req_valid_i = 1'b0;
    logic       req_ready_o;
    logic [1:0] req_op_i    = '0;
    logic [2:0] req_list_i  = '0;
    logic [4:0] req_eid_i   = '0;
    logic       resp_valid_o;
    logic [4:0] resp_eid_o;
    logic       resp_err_o;
    logic [2:0] qry_list_i  = '0;
    logic [4:0] qry_head_o;
    logic [4:0] qry_tail_o;
    logic [4:0] qry_count_o;

    logic       init6;
    logic       req6Valid   = 1'b0;
    logic       ready6;
    logic [1:0] req6Op      = '0;
    logic [2:0] req6List    = '0;
    logic [4:0] req6Eid     = '0;
    logic       resp6Valid;
    logic [4:0] resp6Eid;
    logic       resp6Err;
    logic [2:0] qry6List    = '0;
    logic [4:0] qry6Head;
    logic [4:0] qry6Tail;
    logic [4:0] qry6Count;

    int vectors     = 0;
    int miscompares = 0;

    hawk_tol_list_mngr #(.NUM_LISTS(8), .ENTRY_CNT(16)) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .init_done_o (init_done_o),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_op_i    (req_op_i),
        .req_list_i  (req_list_i),
        .req_eid_i   (req_eid_i),
        .resp_valid_o(resp_valid_o),
        .resp_eid_o  (resp_eid_o),
        .resp_err_o  (resp_err_o),
        .qry_list_i  (qry_list_i),
        .qry_head_o  (qry_head_o),
        .qry_tail_o  (qry_tail_o),
        .qry_count_o (qry_count_o)
    );

    hawk_tol_list_mngr #(.NUM_LISTS(6), .ENTRY_CNT(16)) u_dut6 (
        .clk_i       (clk),
        .rst_i       (rst),
        .init_done_o (init6),
        .req_valid_i (req6Valid),
        .req_ready_o (ready6),
        .req_op_i    (req6Op),
        .req_list_i  (req6List),
        .req_eid_i   (req6Eid),
        .resp_valid_o(resp6Valid),
        .resp_eid_o  (resp6Eid),
        .resp_err_o  (resp6Err),
        .qry_list_i  (qry6List),
        .qry_head_o  (qry6Head),
        .qry_tail_o  (qry6Tail),
        .qry_count_o (qry6Count)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkQuery(input int list, input int h, input int t, input int c);
        qry_list_i = 3'(list);
        #1;
        checkOutput($sformatf("qry list%0d head", list),  32'(qry_head_o),  32'(h));
        checkOutput($sformatf("qry list%0d tail", list),  32'(qry_tail_o),  32'(t));
        checkOutput($sformatf("qry list%0d count", list), 32'(qry_count_o), 32'(c));
    endtask

    // One command: present at a falling edge, accepted at the next rising
    // edge, response checked in the following cycle, then back to idle.
    task automatic applyStimulus(input int op, input int list, input int eid,
                                 input int expEid, input int expErr);
        string tag;
        tag = $sformatf("op%0d list%0d eid%0d", op, list, eid);
        @(negedge clk);
        req_op_i    = 2'(op);
        req_list_i  = 3'(list);
        req_eid_i   = 5'(eid);
        req_valid_i = 1'b1;
        checkOutput({tag, " ready"}, 32'(req_ready_o), 32'd1);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        checkOutput({tag, " resp_valid"}, 32'(resp_valid_o), 32'd1);
        checkOutput({tag, " resp_eid"},   32'(resp_eid_o),   32'(expEid));
        checkOutput({tag, " resp_err"},   32'(resp_err_o),   32'(expErr));
        checkOutput({tag, " ready in resp"}, 32'(req_ready_o), 32'd0);
        @(negedge clk);
        checkOutput({tag, " resp_valid drop"}, 32'(resp_valid_o), 32'd0);
        checkOutput({tag, " resp_eid idle"},   32'(resp_eid_o),   32'd0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("reset init_done",  32'(init_done_o),  32'd0);
        checkOutput("reset ready",      32'(req_ready_o),  32'd0);
        checkOutput("reset resp_valid", 32'(resp_valid_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Count cycles until the free list is built; bounded at 40 cycles.
    task automatic waitInit(input string tag);
        int cyc = 0;
        logic sawReady = 1'b0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (!init_done_o && req_ready_o) sawReady = 1'b1;
        end while (!init_done_o && cyc < 40);
        checkOutput({tag, " init cycles"}, 32'(cyc), 32'd16);
        checkOutput({tag, " ready during init"}, 32'(sawReady), 32'd0);
    endtask

    task automatic checkFreshState(input string tag);
        checkQuery(0, 1, 16, 16);
        for (int l = 1; l < 8; l++) checkQuery(l, 0, 0, 0);
        checkOutput({tag, " ready after init"}, 32'(req_ready_o), 32'd1);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        doReset();
        waitInit("first");
        checkFreshState("first");

        // Six-list instance: list 6 is out of range, list 7 queries as empty.
        qry6List = 3'd6;
        #1;
        checkOutput("dut6 qry list6 head",  32'(qry6Head),  32'd0);
        checkOutput("dut6 qry list6 count", 32'(qry6Count), 32'd0);
        qry6List = 3'd0;
        #1;
        checkOutput("dut6 qry list0 tail",  32'(qry6Tail),  32'd16);
        @(negedge clk);
        req6Op    = 2'd1;
        req6List  = 3'd6;
        req6Valid = 1'b1;
        checkOutput("dut6 ready", 32'(ready6), 32'd1);
        @(posedge clk);
        #1;
        req6Valid = 1'b0;
        @(negedge clk);
        checkOutput("dut6 list6 resp_valid", 32'(resp6Valid), 32'd1);
        checkOutput("dut6 list6 resp_err",   32'(resp6Err),   32'd1);
        checkOutput("dut6 list6 resp_eid",   32'(resp6Eid),   32'd0);
        checkOutput("dut6 init_done",        32'(init6),      32'd1);
        qry6List = 3'd0;
        #1;
        checkOutput("dut6 list0 count kept", 32'(qry6Count), 32'd16);

        // Pop three from FREE, push them onto list 3 in order 2,1,3.
        applyStimulus(1, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 2, 0);
        applyStimulus(1, 0, 0, 3, 0);
        checkQuery(0, 4, 16, 13);
        applyStimulus(0, 3, 2, 2, 0);
        applyStimulus(0, 3, 1, 1, 0);
        applyStimulus(0, 3, 3, 3, 0);
        checkQuery(3, 2, 3, 3);

        // Detach middle, then head, then tail.
        applyStimulus(2, 3, 1, 1, 0);
        checkQuery(3, 2, 3, 2);
        applyStimulus(2, 3, 2, 2, 0);
        checkQuery(3, 3, 3, 1);
        applyStimulus(2, 3, 3, 3, 0);
        checkQuery(3, 0, 0, 0);

        // Rejected commands leave every list untouched.
        applyStimulus(1, 5, 0, 0, 1);
        applyStimulus(0, 3, 4, 0, 1);
        applyStimulus(0, 3, 0, 0, 1);
        applyStimulus(0, 3, 17, 0, 1);
        applyStimulus(2, 1, 5, 0, 1);
        applyStimulus(2, 3, 1, 0, 1);
        applyStimulus(3, 0, 4, 0, 1);
        checkQuery(0, 4, 16, 13);
        checkQuery(1, 0, 0, 0);
        checkQuery(3, 0, 0, 0);
        checkQuery(5, 0, 0, 0);

        // Return 1,2,3 to FREE, then drain it completely.
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(0, 0, 2, 2, 0);
        applyStimulus(0, 0, 3, 3, 0);
        checkQuery(0, 4, 3, 16);
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1, 0, 0, (k < 13) ? k + 4 : k - 12, 0);
        end
        applyStimulus(1, 0, 0, 0, 1);
        checkQuery(0, 0, 0, 0);
        applyStimulus(0, 0, 9, 9, 0);
        checkQuery(0, 9, 9, 1);
        applyStimulus(1, 0, 0, 9, 0);
        checkQuery(0, 0, 0, 0);

        // Reset seven cycles into the build.
        doReset();
        repeat (7) @(posedge clk);
        #1;
        checkOutput("mid-init init_done", 32'(init_done_o), 32'd0);
        doReset();
        waitInit("mid-init restart");
        checkFreshState("mid-init restart");

        // Reset raised in the response cycle of an accepted pop.
        @(negedge clk);
        req_op_i    = 2'd1;
        req_list_i  = 3'd0;
        req_valid_i = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("resp-reset resp_valid", 32'(resp_valid_o), 32'd0);
        checkOutput("resp-reset resp_eid",   32'(resp_eid_o),   32'd0);
        checkOutput("resp-reset resp_err",   32'(resp_err_o),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("resp-reset resp_valid after", 32'(resp_valid_o), 32'd0);
        waitInit("resp restart");
        checkFreshState("resp restart");
        applyStimulus(1, 0, 0, 1, 0);
        checkQuery(0, 2, 16, 15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hawk_tol_list_mngr.md
Name: hawk_tol_list_mngr

Overview:
- Parametrised successor to the fixed ToL head/tail bookkeeping, which handled free, uncomp, incomp and one irregular free list.
- Manages NUM_LISTS doubly linked lists over a shared pool of list entry IDs.
- Stores next/prev/owner links on chip and keeps head, tail and count for every list.
- Serves push-tail, pop-head and detach commands from the hawk control unit and builds the initial free list (list 0) after reset.

Parameters:
NUM_LISTS, 8, number of lists; list 0 = FREE, 1 = UNCOMP, 2 = INCOMP, 3..NUM_LISTS-1 = irregular free lists
ENTRY_CNT, 16, usable entry IDs 1..ENTRY_CNT; ID 0 = NULL
ID_W, $clog2(ENTRY_CNT+1), entry ID / count width
LW, $clog2(NUM_LISTS) (min 1), list index width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
init_done_o  out  1  free list build complete
req_valid_i  in  1  command valid
req_ready_o  out  1  command accepted when valid&ready
req_op_i  in  2  0=PUSH_TAIL, 1=POP_HEAD, 2=DETACH, 3=reserved (error)
req_list_i  in  LW  target list
req_eid_i  in  ID_W  entry for PUSH/DETACH; ignored for POP
resp_valid_o  out  1  one-cycle response strobe
resp_eid_o  out  ID_W  pushed/popped/detached entry; 0 on error
resp_err_o  out  1  command rejected, no state change
qry_list_i  in  LW  query index
qry_head_o  out  ID_W  head of qry_list_i (combinational from registers)
qry_tail_o  out  ID_W  tail of qry_list_i
qry_count_o  out  ID_W  entry count of qry_list_i

Behaviour:
- Storage: next[], prev[] and owner[] per entry 0..ENTRY_CNT. owner is LW+1 bits; value NUM_LISTS = unowned. head, tail and count per list. All in flops.
- FSM states: INIT, IDLE, RESP.
- Reset (at any time, including mid-INIT or mid-RESP):
  - state=INIT, build index i=1.
  - All heads/tails=0, counts=0, owners=unowned.
  - Outputs: init_done_o=0, req_ready_o=0, resp_valid_o=0, resp_eid_o=0, resp_err_o=0.
- INIT: one entry per cycle, i=1..ENTRY_CNT.
  - next[i] = (i==ENTRY_CNT)?0:i+1; prev[i]=i-1; owner[i]=0.
  - After the last write: head0=1, tail0=ENTRY_CNT, count0=ENTRY_CNT.
  - Go to IDLE. init_done_o=1 from the first IDLE cycle, i.e. ENTRY_CNT cycles after rst_i deasserts, and stays 1 until the next reset.
- IDLE: req_ready_o=1. On valid&ready, evaluate the command against current registers, commit all updates at that clock edge, go to RESP.
- RESP: resp_valid_o=1 for exactly one cycle, req_ready_o=0, then IDLE. Latency accept→response is 1 cycle; maximum throughput is 1 command per 2 cycles. resp_eid_o/resp_err_o are valid only while resp_valid_o=1 and are 0 otherwise.
- Error checks (any failure → resp_err_o=1, resp_eid_o=0, no register change): req_list_i>=NUM_LISTS; op==3.
- PUSH_TAIL:
  - Error if eid==0, eid>ENTRY_CNT, or owner[eid]!=unowned.
  - Otherwise: next[eid]=0, prev[eid]=tail, owner[eid]=list, count+1.
  - Empty list: head=tail=eid. Non-empty: next[old tail]=eid, tail=eid.
- POP_HEAD:
  - Error if count==0.
  - Otherwise return h=head; head=next[h], owner[h]=unowned, count-1.
  - If the list becomes empty, tail=0; else prev[new head]=0.
- DETACH:
  - Error if eid invalid or owner[eid]!=req_list_i.
  - Unlink by cases:
    - Only entry: head=tail=0.
    - Head: head=next, prev[next]=0.
    - Tail: tail=prev, next[prev]=0.
    - Middle: next[prev]=next, prev[next]=prev.
  - Then owner=unowned, count-1, and clear next[eid]/prev[eid] to 0.
- Count never wraps. Overflow is impossible because each entry has a single owner.
- Query port: qry_list_i>=NUM_LISTS returns 0/0/0. Values reflect registers, so an update is visible the cycle after the accept edge.

Test Plan:
- Reset, idle 16 cycles → init_done_o rises at cycle 16; qry list0 head=1, tail=16, count=16; lists 1..7 all zero; req_ready_o=0 during INIT.
- POP_HEAD list0 ×3 → resp_eid 1,2,3 on cycles +1 of each accept; list0 head=4, count=13. Then PUSH_TAIL list3 with eids 2,1,3 → list3 head=2, tail=3, count=3.
- DETACH eid1 (middle) from list3 → list3 is 2→3, count=2. Then DETACH 2 (head), then DETACH 3 (tail) → list3 head=tail=count=0.
- Errors, each giving resp_err=1, resp_eid=0, no change:
  - POP on empty list5
  - PUSH eid 4, still owned by list0
  - PUSH eid 0
  - PUSH eid 17
  - DETACH eid 5 from list1
  - req_list=8 (LW=3 wraps to 0, so use NUM_LISTS=6, list=6)
  - op=3
- Drain list0 with 16 POPs → 17th POP errors; list0 tail=0, count=0. PUSH eid 9 → head=tail=9.
- Assert rst_i mid-INIT (cycle 7) and in the RESP cycle → full restart, state identical to the first scenario, no spurious resp_valid_o.
